ifu_axi4_burst_bridge: RTL and testbench

Converts the instruction cache's single-cycle burst refill request (`mem_req`/`mem_addr`/`mem_len`) into an AXI4 read transaction: one AR handshake and an INCR burst on R. Returns each beat to the cache as `mem_rvalid`/`mem_rdata`/`mem_rlast`. Sits between the ICache refill port and the SoC AXI4 crossbar. Handles cache flush mid-transaction by draining the outstanding burst silently, since AXI4 cannot abort it.

---
 rtl/ifu_axi_pkg.sv | 16 +
 rtl/ifu_axi4_burst_bridge_if.sv | 45 ++++
 rtl/ifu_axi4_burst_bridge_perf.sv | 33 +++
 rtl/ifu_axi4_burst_bridge.sv | 158 +++++++++++++++
 tb/tb_ifu_axi4_burst_bridge.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/ifu_axi_pkg.sv
// Shared types and AXI4 encodings for the ICache refill bridge.
package ifu_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_AR    = 2'd1,
    ST_R     = 2'd2,
    ST_DRAIN = 2'd3
  } ifu_axi_state_e;

  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ifu_axi4_burst_bridge_if.sv
// Bundle of ICache refill port and AXI4 read channels; master = bridge view.
interface ifu_axi4_burst_bridge_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_len;
  logic                  mem_flush;
  logic                  mem_rvalid;
  logic [31:0]           mem_rdata;
  logic                  mem_rlast;
  logic                  mem_err;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arid;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic [3:0]            rid;

  modport master (
    input  mem_req, mem_addr, mem_len, mem_flush,
    output mem_rvalid, mem_rdata, mem_rlast, mem_err,
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rresp, rlast, rid,
    output rready
  );

  modport slave (
    output mem_req, mem_addr, mem_len, mem_flush,
    input  mem_rvalid, mem_rdata, mem_rlast, mem_err,
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rresp, rlast, rid,
    input  rready
  );
endinterface

// File: rtl/ifu_axi4_burst_bridge_perf.sv
// Simulation performance counters for the refill bridge (IFU_AXI_PERF_EN builds only).
module ifu_axi_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        ar_hs,
  input  logic        beat_fwd,
  input  logic        beat_drop,
  input  logic        ar_stall,
  input  logic        lat_tick,
  output logic [63:0] perf_ar_cnt,
  output logic [63:0] perf_beat_cnt,
  output logic [63:0] perf_drain_beats,
  output logic [63:0] perf_ar_stall,
  output logic [63:0] perf_lat_sum
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ar_cnt      <= '0;
      perf_beat_cnt    <= '0;
      perf_drain_beats <= '0;
      perf_ar_stall    <= '0;
      perf_lat_sum     <= '0;
    end else begin
      perf_ar_cnt      <= perf_ar_cnt      + {63'd0, ar_hs};
      perf_beat_cnt    <= perf_beat_cnt    + {63'd0, beat_fwd};
      perf_drain_beats <= perf_drain_beats + {63'd0, beat_drop};
      perf_ar_stall    <= perf_ar_stall    + {63'd0, ar_stall};
      perf_lat_sum     <= perf_lat_sum     + {63'd0, lat_tick};
    end
  end

endmodule

// File: rtl/ifu_axi4_burst_bridge.sv
// ICache refill -> AXI4 INCR read bridge with flush drain and one pending slot.
// Optional perf counters under `IFU_AXI_PERF_EN`.
module ifu_axi4_burst_bridge
  import ifu_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  ifu_axi4_burst_bridge_if.master  bus
);

  ifu_axi_state_e        state, state_nx;
  logic                  cancel, cancel_nx;
  logic                  pend_v, pend_v_nx, pend_load;
  logic [ADDR_WIDTH-1:0] pend_addr;
  logic [7:0]            pend_len;
  logic                  launch;
  logic [ADDR_WIDTH-1:0] launch_addr;
  logic [7:0]            launch_len;
  logic                  req_ok, beat, fwd, drop;

  logic                  arvalid_q, rready_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [7:0]            arlen_q;
  logic                  mem_rvalid_q, mem_rlast_q, mem_err_q;
  logic [31:0]           mem_rdata_q;

  always_comb begin
    state_nx    = state;
    cancel_nx   = cancel;
    pend_v_nx   = pend_v;
    launch      = 1'b0;
    launch_addr = bus.mem_addr;
    launch_len  = bus.mem_len;
    fwd         = 1'b0;
    drop        = 1'b0;
    req_ok      = bus.mem_req && !bus.mem_flush;
    beat        = bus.rvalid && rready_q;
    pend_load   = (state != ST_IDLE) && req_ok;

    case (state)
      ST_IDLE: begin
        // A fresh request supersedes the parked one; flush discards both.
        if (req_ok) begin
          launch = 1'b1;
        end else if (pend_v && !bus.mem_flush) begin
          launch      = 1'b1;
          launch_addr = pend_addr;
          launch_len  = pend_len;
        end
        pend_v_nx = 1'b0;
        if (launch) state_nx = ST_AR;
      end
      ST_AR: begin
        if (bus.arready) state_nx = (cancel || bus.mem_flush) ? ST_DRAIN : ST_R;
        else if (bus.mem_flush) cancel_nx = 1'b1;
      end
      ST_R: begin
        fwd = beat && !bus.mem_flush;
        drop = beat && bus.mem_flush;
        if (beat && bus.rlast) state_nx = ST_IDLE;
        else if (bus.mem_flush) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        drop = beat;
        if (beat && bus.rlast) begin
          state_nx  = ST_IDLE;
          cancel_nx = 1'b0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    if (state != ST_IDLE) begin
      if (bus.mem_flush) pend_v_nx = 1'b0;
      else if (bus.mem_req) pend_v_nx = 1'b1;
    end
  end

  // Control, AR and beat registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cancel       <= 1'b0;
      pend_v       <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      mem_rvalid_q <= 1'b0;
      mem_rlast_q  <= 1'b0;
      mem_err_q    <= 1'b0;
      mem_rdata_q  <= '0;
    end else begin
      state        <= state_nx;
      cancel       <= cancel_nx;
      pend_v       <= pend_v_nx;
      arvalid_q    <= (state_nx == ST_AR);
      rready_q     <= (state_nx == ST_R) || (state_nx == ST_DRAIN);
      if (launch) begin
        araddr_q <= launch_addr;
        arlen_q  <= launch_len;
      end
      mem_rvalid_q <= fwd;
      mem_rlast_q  <= fwd && bus.rlast;
      mem_err_q    <= fwd && bus.rresp[1];
      if (fwd) mem_rdata_q <= bus.rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (pend_load) begin
      pend_addr <= bus.mem_addr;
      pend_len  <= bus.mem_len;
    end
  end

  assign bus.arvalid    = arvalid_q;
  assign bus.araddr     = araddr_q;
  assign bus.arlen      = arlen_q;
  assign bus.arid       = AXI_ID;
  assign bus.arsize     = AXI_SIZE_4B;
  assign bus.arburst    = AXI_BURST_INCR;
  assign bus.rready     = rready_q;
  assign bus.mem_rvalid = mem_rvalid_q;
  assign bus.mem_rdata  = mem_rdata_q;
  assign bus.mem_rlast  = mem_rlast_q;
  assign bus.mem_err    = mem_err_q;

  // rid is deliberately ignored; only rresp[1] distinguishes error responses.
  logic unused_rsp;
  assign unused_rsp = ^{bus.rid, bus.rresp[0]};

`ifdef IFU_AXI_PERF_EN
  logic [63:0] perf_ar_cnt, perf_beat_cnt, perf_drain_beats, perf_ar_stall, perf_lat_sum;

  ifu_axi_perf u_perf (
    .clk              (clk),
    .rst              (rst),
    .ar_hs            (arvalid_q && bus.arready),
    .beat_fwd         (fwd),
    .beat_drop        (drop),
    .ar_stall         (arvalid_q && !bus.arready),
    .lat_tick         ((state == ST_R) || (state == ST_DRAIN)),
    .perf_ar_cnt      (perf_ar_cnt),
    .perf_beat_cnt    (perf_beat_cnt),
    .perf_drain_beats (perf_drain_beats),
    .perf_ar_stall    (perf_ar_stall),
    .perf_lat_sum     (perf_lat_sum)
  );
`else
  logic unused_perf;
  assign unused_perf = drop;
`endif

endmodule

// File: tb/tb_ifu_axi4_burst_bridge.sv
// Directed self-checking bench for ifu_axi4_burst_bridge.
module tb_ifu_axi4_burst_bridge;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  ifu_axi4_burst_bridge_if #(.ADDR_WIDTH(32)) bus ();

  ifu_axi4_burst_bridge #(
    .AXI_ID     (4'd0),
    .ADDR_WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic [31:0] addr, input logic [7:0] len);
    bus.mem_req  = 1'b1;
    bus.mem_addr = addr;
    bus.mem_len  = len;
    tick();
    bus.mem_req  = 1'b0;
  endtask

  // Presents n back-to-back beats; expects forwarding (or silence) one cycle after each.
  task automatic run_beats(input int n, input logic [31:0] base, input int err_idx, input bit fwd);
    for (int i = 0; i < n; i++) begin
      chk("rready_in_burst", bus.rready, 1);
      bus.rvalid = 1'b1;
      bus.rdata  = base + i;
      bus.rlast  = (i == n - 1);
      bus.rresp  = (i == err_idx) ? 2'b10 : 2'b00;
      tick();
      chk("mem_rvalid", bus.mem_rvalid, fwd);
      if (fwd) begin
        chk("mem_rdata", bus.mem_rdata, base + i);
        chk("mem_rlast", bus.mem_rlast, (i == n - 1));
        chk("mem_err", bus.mem_err, (i == err_idx));
      end
    end
    bus.rvalid = 1'b0;
    bus.rlast  = 1'b0;
    bus.rresp  = 2'b00;
    chk("rready_after_last", bus.rready, 0);
    tick();
    chk("mem_rvalid_pulse_end", bus.mem_rvalid, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus.mem_req = 1'b0; bus.mem_addr = '0; bus.mem_len = '0; bus.mem_flush = 1'b0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00;
    bus.rlast = 1'b0; bus.rid = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();

    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_mem_rvalid", bus.mem_rvalid, 0);
    chk("rst_mem_rlast", bus.mem_rlast, 0);
    chk("rst_mem_err", bus.mem_err, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arlen", bus.arlen, 0);
    chk("rst_mem_rdata", bus.mem_rdata, 0);

    // Basic burst, arready immediate
    bus.arready = 1'b1;
    request(32'h3000_0010, 8'd3);
    chk("t1_arvalid", bus.arvalid, 1);
    chk("t1_araddr", bus.araddr, 32'h3000_0010);
    chk("t1_arlen", bus.arlen, 3);
    chk("t1_arburst", bus.arburst, 2'b01);
    chk("t1_arsize", bus.arsize, 3'b010);
    chk("t1_arid", bus.arid, 0);
    chk("t1_rready_in_ar", bus.rready, 0);
    tick();
    chk("t1_arvalid_drop", bus.arvalid, 0);
    run_beats(4, 32'hA0, -1, 1'b1);

    // Request and flush in the same cycle: request dropped
    bus.mem_flush = 1'b1;
    request(32'h3000_00F0, 8'd1);
    bus.mem_flush = 1'b0;
    chk("req_flush_drop", bus.arvalid, 0);
    tick();
    chk("req_flush_drop2", bus.arvalid, 0);

    // AR backpressure for 5 cycles
    bus.arready = 1'b0;
    request(32'h3000_0020, 8'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_arvalid_hold", bus.arvalid, 1);
      chk("t2_araddr_hold", bus.araddr, 32'h3000_0020);
      chk("t2_rready_stall", bus.rready, 0);
      tick();
    end
    chk("t2_arvalid_hs", bus.arvalid, 1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("t2_arvalid_drop", bus.arvalid, 0);
    run_beats(2, 32'h20, -1, 1'b1);

    // Flush in R after 2 of 4 beats, new request two cycles later
    bus.arready = 1'b1;
    request(32'h3000_0030, 8'd3);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hB0;
    tick();
    chk("t3_fwd_b0", bus.mem_rdata, 32'hB0);
    bus.rdata = 32'hB1;
    tick();
    chk("t3_fwd_b1", bus.mem_rvalid, 1);
    bus.rvalid = 1'b0;
    bus.mem_flush = 1'b1;
    tick();
    bus.mem_flush = 1'b0;
    chk("t3_flush_cycle", bus.mem_rvalid, 0);
    chk("t3_drain_rready", bus.rready, 1);
    bus.rvalid = 1'b1; bus.rdata = 32'hB2;
    tick();
    chk("t3_drop_b2", bus.mem_rvalid, 0);
    bus.mem_req = 1'b1; bus.mem_addr = 32'h3000_0040; bus.mem_len = 8'd3;
    bus.rdata = 32'hB3; bus.rlast = 1'b1;
    tick();
    bus.mem_req = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0;
    chk("t3_drop_b3", bus.mem_rvalid, 0);
    chk("t3_idle_arvalid", bus.arvalid, 0);
    tick();
    chk("t3_pend_arvalid", bus.arvalid, 1);
    chk("t3_pend_araddr", bus.araddr, 32'h3000_0040);
    chk("t3_pend_arlen", bus.arlen, 3);
    tick();
    run_beats(4, 32'hC0, -1, 1'b1);

    // Flush during AR stall: arvalid held, whole burst drained
    bus.arready = 1'b0;
    request(32'h3000_0050, 8'd2);
    chk("t4_arvalid", bus.arvalid, 1);
    bus.mem_flush = 1'b1;
    tick();
    bus.mem_flush = 1'b0;
    chk("t4_arvalid_kept", bus.arvalid, 1);
    tick();
    chk("t4_arvalid_kept2", bus.arvalid, 1);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    chk("t4_arvalid_drop", bus.arvalid, 0);
    run_beats(3, 32'hD0, -1, 1'b0);

    // SLVERR on second beat
    bus.arready = 1'b1;
    request(32'h3000_0060, 8'd3);
    tick();
    run_beats(4, 32'hE0, 1, 1'b1);

    // Async reset mid-burst
    request(32'h3000_0070, 8'd3);
    tick();
    bus.rvalid = 1'b1; bus.rdata = 32'hF0;
    tick();
    chk("t6_beat0", bus.mem_rvalid, 1);
    bus.rdata = 32'hF1;
    #2 rst = 1'b1;
    #1;
    chk("t6_async_mem_rvalid", bus.mem_rvalid, 0);
    chk("t6_async_mem_rdata", bus.mem_rdata, 0);
    chk("t6_async_rready", bus.rready, 0);
    chk("t6_async_araddr", bus.araddr, 0);
    chk("t6_async_arlen", bus.arlen, 0);
    bus.rvalid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    bus.arready = 1'b0;
    request(32'h3000_0080, 8'd0);
    chk("t6_fresh_arvalid", bus.arvalid, 1);
    chk("t6_fresh_araddr", bus.araddr, 32'h3000_0080);
    chk("t6_fresh_arlen", bus.arlen, 0);
    bus.arready = 1'b1;
    tick();
    bus.arready = 1'b0;
    run_beats(1, 32'h90, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
